// File: rtl/frequencimetro_auto_ctrl.sv
// Frequency-meter controller: counts synchronised rising edges of amostra over a
// range-dependent gate window and latches the BCD result, with optional auto-ranging.
module frequencimetro_auto_ctrl #(
  parameter int  NDIGITS     = 5,
  parameter int  BASE_GATE   = 1000,
  parameter int  NUM_RANGES  = 4,
  parameter int  HOLD_CYCLES = 2,
  parameter int  SYNC_STAGES = 2,
  localparam int RW          = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 auto,
  input  logic [RW-1:0]        seletor,
  input  logic                 amostra,
  output logic [4*NDIGITS-1:0] digits,
  output logic [RW-1:0]        range,
  output logic                 valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int DW = 4 * NDIGITS;

  function automatic int unsigned gate_len(input int r);
    int unsigned g;
    g = int'(BASE_GATE);
    for (int i = 0; i < r; i++) g = g * 32'd10;
    return g;
  endfunction

  localparam int unsigned MAX_GATE = gate_len(NUM_RANGES - 1);
  localparam int          GW       = (MAX_GATE > 1) ? $clog2(MAX_GATE) : 1;
  localparam int          HW       = $clog2(HOLD_CYCLES + 1);

  // Terminal gate-counter value for a runtime range: a chain of constant x10 steps.
  function automatic logic [GW-1:0] last_gate(input logic [RW-1:0] r);
    int unsigned g;
    g = int'(BASE_GATE);
    for (int i = 1; i < NUM_RANGES; i++) begin
      if (i <= int'(r)) g = g * 32'd10;
      else              g = g;
    end
    return GW'(g - 32'd1);
  endfunction

  function automatic logic all_nines(input logic [DW-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NDIGITS; i++) r = r & (v[4*i +: 4] == 4'd9);
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic          carry;
    logic [DW-1:0] r;
    carry = 1'b1;
    r     = v;
    for (int i = 0; i < NDIGITS; i++) begin
      if (carry && v[4*i +: 4] == 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATE, S_LATCH, S_HOLD} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [DW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [GW-1:0]          gate_cnt_q;
  logic [HW-1:0]          hold_cnt_q;
  logic [RW-1:0]          range_int_q, auto_rng_q, auto_rng_d;
  logic [RW-1:0]          sel_clamped;
  logic [DW-1:0]          digits_q;
  logic [RW-1:0]          range_q;
  logic                   valid_q, overflow_q, busy_q;
  logic                   rise_pulse;
  logic                   gate_done;

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign gate_done  = (gate_cnt_q == last_gate(range_int_q));

  always_comb begin
    if (int'(seletor) >= NUM_RANGES) sel_clamped = RW'(NUM_RANGES - 1);
    else                             sel_clamped = seletor;
  end

  // Next count includes this cycle's edge; the auto decision looks at that final value.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (rise_pulse && all_nines(count_q)) begin
      ovf_d = 1'b1;
    end else if (rise_pulse) begin
      count_d = bcd_inc(count_q);
    end else begin
      count_d = count_q;
    end

    if (ovf_d && range_int_q != '0) begin
      auto_rng_d = range_int_q - RW'(1);
    end else if (count_d[DW-1 -: 4] == 4'd0 && int'(range_int_q) < NUM_RANGES - 1) begin
      auto_rng_d = range_int_q + RW'(1);
    end else begin
      auto_rng_d = range_int_q;
    end
  end

  // Results are written on the GATE->LATCH edge so valid and the new digits appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      gate_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      range_int_q <= '0;
      auto_rng_q  <= '0;
      digits_q    <= '0;
      range_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], amostra};
      prev_q  <= sync_q[SYNC_STAGES-1];
      valid_q <= 1'b0;
      if (!run) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_CLEAR;
          end
          S_CLEAR: begin
            count_q     <= '0;
            ovf_q       <= 1'b0;
            gate_cnt_q  <= '0;
            range_int_q <= auto ? auto_rng_q : sel_clamped;
            state_q     <= S_GATE;
            busy_q      <= 1'b1;
          end
          S_GATE: begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (gate_done) begin
              state_q    <= S_LATCH;
              busy_q     <= 1'b0;
              digits_q   <= count_d;
              range_q    <= range_int_q;
              overflow_q <= ovf_d;
              valid_q    <= 1'b1;
              auto_rng_q <= auto_rng_d;
            end else begin
              gate_cnt_q <= gate_cnt_q + GW'(1);
            end
          end
          S_LATCH: begin
            hold_cnt_q <= '0;
            state_q    <= S_HOLD;
          end
          S_HOLD: begin
            if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) state_q <= S_CLEAR;
            else                                   hold_cnt_q <= hold_cnt_q + HW'(1);
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digits   = digits_q;
  assign range    = range_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule
